// File: rtl/ca_rng_if.sv
// ca_rng_if: seed, request/grant and random-word signals of the CA random number controller
interface ca_rng_if;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [15:0] rnd_out;
  logic        busy;
  modport master (output seed_load, seed_in, req, input gnt, rnd_out, busy);
  modport slave  (input seed_load, seed_in, req, output gnt, rnd_out, busy);
endinterface

// File: rtl/ca_rng_ctrl.sv
// ca_rng_ctrl: hybrid rule-90/150 CA generator with warm-up and round-robin delivery of
// one random word per grant to two requesters
module ca_rng_ctrl #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int unsigned WARMUP = 16
) (
  input logic     clk,
  input logic     rst,
  ca_rng_if.slave bus
);
  typedef enum logic {WARM, READY} state_t;
  localparam state_t     INIT_ST = (WARMUP == 0) ? READY : WARM;
  localparam logic [7:0] WARM_N  = 8'(WARMUP);
  state_t      fsm_q, fsm_d;
  logic [15:0] s_q, s_d, rnd_q, rnd_d, s_step;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d, elig;
  logic        prio_q, prio_d, ready;
  always_comb begin
    ready  = fsm_q == READY;
    // rule 150 on even cells, rule 90 on odd cells; shifts give null boundaries
    s_step = s_q == '0 ? SEED : (s_q << 1) ^ (s_q >> 1) ^ (s_q & 16'h5555);
    elig   = bus.req & ~gnt_q & {2{ready && !bus.seed_load}};
    gnt_d  = elig == 2'b11 ? (prio_q ? 2'b10 : 2'b01) : elig;
    prio_d = gnt_d[0] ? 1'b1 : gnt_d[1] ? 1'b0 : prio_q;
    s_d    = bus.seed_load ? (bus.seed_in == '0 ? SEED : bus.seed_in)
           : (!ready || gnt_q != 2'b00) ? s_step : s_q;
    rnd_d  = gnt_d != 2'b00 ? s_d : rnd_q;
    cnt_d  = bus.seed_load ? WARM_N : ready ? cnt_q : cnt_q - 8'd1;
    fsm_d  = bus.seed_load ? INIT_ST : (!ready && cnt_q == 8'd1) ? READY : fsm_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= INIT_ST;
      s_q    <= SEED;
      cnt_q  <= WARM_N;
      gnt_q  <= 2'b00;
      rnd_q  <= 16'h0000;
      prio_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_d;
      rnd_q  <= rnd_d;
      prio_q <= prio_d;
    end
  end
  assign bus.gnt     = gnt_q;
  assign bus.rnd_out = rnd_q;
  assign bus.busy    = fsm_q == WARM;
endmodule
